tx_packet_generator: RTL

Parametrised successor to the single-stream USB test-data generator. Builds framed packets (header, payload, XOR trailer) for up to CHANNELS logical channels, arbitrated round-robin, with selectable payload pattern and single-shot or continuous mode. It drives the FT245 core TX write port under `tx_full` back-pressure and sits between the user clock generator and `core_ft245`.

---
 rtl/tx_gen_pkg.sv | 37 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/tx_packet_generator.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/tx_gen_pkg.sv
// Shared constants, enums and the LFSR step for the TX packet generator.
// Holds no logic of its own, so it adds no latency and has no backpressure.
package tx_gen_pkg;

  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
  localparam logic [7:0]  CONST_BYTE = 8'h5A;
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_SINGLE = 2'd1,
    MODE_CONT   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    PAT_COUNT = 2'd0,
    PAT_LFSR  = 2'd1,
    PAT_WALK  = 2'd2,
    PAT_CONST = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_HDR,
    ST_PAY,
    ST_TRL
  } state_e;

  // Galois form: shift right, fold the taps back in when a one drops out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first requester strictly after `last`, wrapping around.
// Purely combinational (zero latency); the pointer register lives in the parent.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= N) ? s - N : s;
  endfunction

  // Scan farthest to nearest so the nearest requester after `last` wins.
  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[IW'(wrap_idx(int'(last), k))]) begin
        grant_idx   = IW'(wrap_idx(int'(last), k));
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_packet_generator.sv
// Framed test-packet source (header, payload, XOR trailer) over round-robin channels.
// Trigger edge to ARB 3 cycles, ARB to first write 1 cycle; tx_full stalls state and tx_data.
module tx_packet_generator
  import tx_gen_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CHANNELS = 4,
  parameter int LEN_W    = 12
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                trigger,
  input  logic [1:0]          mode,
  input  logic [1:0]          pattern_sel,
  input  logic [CHANNELS-1:0] chan_en,
  input  logic [LEN_W-1:0]    pkt_len,
  input  logic                tx_full,
  output logic                tx_write,
  output logic [DATA_W-1:0]   tx_data,
  output logic                busy,
  output logic [31:0]         pkt_count
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int WK_W = $clog2(DATA_W);
  localparam int REP  = (DATA_W + 31) / 32;

  state_e             state_q, state_d;
  logic [2:0]         sync_q, sync_d;
  logic [CH_W-1:0]    last_q, last_d, chan_q, chan_d, grant_idx;
  logic               grant_valid;
  logic [LEN_W-1:0]   len_q, len_d, rem_q, rem_d;
  pattern_e           pat_q, pat_d;
  logic [WK_W-1:0]    walk_q, walk_d, walk_nxt;
  logic [31:0]        lfsr_q, lfsr_d, lfsr_nxt, pkt_count_q, pkt_count_d;
  logic [DATA_W-1:0]  xor_q, xor_d, tx_data_q, tx_data_d;
  logic [DATA_W-1:0]  cnt_cur, cnt_nxt, hdr_word;
  logic [DATA_W-1:0]  cnt_q [CHANNELS];
  logic [DATA_W-1:0]  cnt_d [CHANNELS];
  logic               trig_edge, any_en, start;
  mode_e              mode_s;

  function automatic logic [DATA_W-1:0] pat_word(input pattern_e p, input logic [DATA_W-1:0] c,
                                                 input logic [31:0] l, input logic [WK_W-1:0] w);
    logic [REP*32-1:0] rep;
    rep = {REP{l}};
    case (p)
      PAT_COUNT: pat_word = c;
      PAT_LFSR:  pat_word = rep[DATA_W-1:0];
      PAT_WALK:  pat_word = {{(DATA_W-1){1'b0}}, 1'b1} << w;
      default:   pat_word = {(DATA_W/8){CONST_BYTE}};
    endcase
  endfunction

  rr_arbiter #(.N(CHANNELS), .IW(CH_W)) u_arb (
    .req         (chan_en),
    .last        (last_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign mode_s    = mode_e'(mode);
  assign any_en    = |chan_en;
  assign trig_edge = sync_q[1] & ~sync_q[2];
  assign start     = any_en & (((mode_s == MODE_SINGLE) & trig_edge) | (mode_s == MODE_CONT));
  assign sync_d    = {sync_q[1:0], trigger};
  assign cnt_cur   = cnt_q[chan_q];
  assign cnt_nxt   = cnt_cur + DATA_W'(1);
  assign lfsr_nxt  = lfsr_step(lfsr_q);
  assign walk_nxt  = (walk_q == WK_W'(DATA_W - 1)) ? '0 : walk_q + WK_W'(1);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      sync_q      <= '0;
      last_q      <= CH_W'(CHANNELS - 1);
      chan_q      <= '0;
      len_q       <= '0;
      rem_q       <= '0;
      pat_q       <= PAT_COUNT;
      walk_q      <= '0;
      lfsr_q      <= LFSR_SEED;
      xor_q       <= '0;
      tx_data_q   <= '0;
      pkt_count_q <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      last_q      <= last_d;
      chan_q      <= chan_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      pat_q       <= pat_d;
      walk_q      <= walk_d;
      lfsr_q      <= lfsr_d;
      xor_q       <= xor_d;
      tx_data_q   <= tx_data_d;
      pkt_count_q <= pkt_count_d;
      cnt_q       <= cnt_d;
    end
  end

  // Mode is only looked at in IDLE and on the trailer write; a started packet always finishes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_ARB;
      ST_ARB:  state_d = grant_valid ? ST_HDR : ST_IDLE;
      ST_HDR:  if (tx_write) state_d = (len_q == '0) ? ST_TRL : ST_PAY;
      ST_PAY:  if (tx_write && rem_q == LEN_W'(1)) state_d = ST_TRL;
      ST_TRL:  if (tx_write) state_d = (mode_s == MODE_CONT && any_en) ? ST_ARB : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hdr_word        = '0;
    hdr_word[31:24] = SYNC_BYTE;
    hdr_word[23:16] = 8'(grant_idx);
    hdr_word[15:0]  = 16'(pkt_len);
  end

  // tx_data always holds the word the next write will emit; pattern state advances per payload write.
  always_comb begin
    last_d      = last_q;
    chan_d      = chan_q;
    len_d       = len_q;
    rem_d       = rem_q;
    pat_d       = pat_q;
    walk_d      = walk_q;
    lfsr_d      = lfsr_q;
    xor_d       = xor_q;
    tx_data_d   = tx_data_q;
    pkt_count_d = pkt_count_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_ARB: begin
        if (grant_valid) begin
          last_d = grant_idx;
          chan_d = grant_idx;
        end
        len_d     = pkt_len;
        pat_d     = pattern_e'(pattern_sel);
        walk_d    = '0;
        xor_d     = '0;
        tx_data_d = hdr_word;
      end
      ST_HDR: if (tx_write) begin
        rem_d     = len_q;
        tx_data_d = (len_q == '0) ? '0 : pat_word(pat_q, cnt_cur, lfsr_q, walk_q);
      end
      ST_PAY: if (tx_write) begin
        xor_d  = xor_q ^ tx_data_q;
        rem_d  = rem_q - LEN_W'(1);
        walk_d = walk_nxt;
        if (pat_q == PAT_COUNT) cnt_d[chan_q] = cnt_nxt;
        if (pat_q == PAT_LFSR)  lfsr_d = lfsr_nxt;
        tx_data_d = (rem_q == LEN_W'(1)) ? (xor_q ^ tx_data_q)
                                         : pat_word(pat_q, cnt_nxt, lfsr_nxt, walk_nxt);
      end
      ST_TRL: if (tx_write) pkt_count_d = pkt_count_q + 32'd1;
      default: ;
    endcase
  end

  always_comb begin
    tx_write = ((state_q == ST_HDR) || (state_q == ST_PAY) || (state_q == ST_TRL))
               && !tx_full && !rst_in;
    busy     = (state_q != ST_IDLE);
  end

  assign tx_data   = tx_data_q;
  assign pkt_count = pkt_count_q;

endmodule
